seq11011_frame_tx: RTL and testbench

Serial frame transmitter that drives the line read by the on-chip 11011 sequence detector. Each accepted payload word becomes one frame on a single-bit line: a 5-bit sync word 11011, then the payload MSB-first, then an optional parity bit, then a mandatory zero gap. It sits between a parallel producer (valid/ready) and the serial pin or loopback into the detector.

---
 rtl/seq_tx_pkg.sv | 21 ++
 rtl/seq_tx_shreg.sv | 38 +++
 rtl/seq11011_frame_tx.sv | 125 ++++++++++++
 tb/tb_seq11011_frame_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state type and sync constants for the 11011 frame transmitter
package seq_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    localparam logic [4:0] SYNC_WORD = 5'b11011;
    localparam int         SYNC_LEN  = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// rtl/seq_tx_shreg.sv - parallel-load MSB-first shift register with bit-down-counter and last-bit flag
module seq_tx_shreg #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     load_data,
    input  logic [CNT_W-1:0] load_len,
    output logic             bit_out,
    output logic             last
);

    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] cnt_q;

    // Counter holds the number of bits still to come after the one on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= load_data;
            cnt_q  <= load_len - CNT_W'(1);
        end else if (shift) begin
            data_q <= data_q << 1;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign bit_out = data_q[W-1];
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/seq11011_frame_tx.sv
// rtl/seq11011_frame_tx.sv - 11011-sync serial frame transmitter; SEQ_TX_PARITY_EN adds an even-parity bit
module seq11011_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int GAP_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 ser_out,
    output logic                 ser_active,
    output logic                 sync_done,
    output logic                 frame_done
);

    localparam int SH_W  = (PAYLOAD_W > SYNC_LEN) ? PAYLOAD_W : SYNC_LEN;
    localparam int CNT_W = $clog2(max3(SYNC_LEN, PAYLOAD_W, GAP_BITS) + 1);

    tx_state_t            state_q, state_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 accept;
    logic                 sh_load, sh_shift, sh_bit, sh_last;
    logic [SH_W-1:0]      sh_data;
    logic [CNT_W-1:0]     sh_len;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            payload_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                payload_q <= in_data;
            end
        end
    end

    // Each phase is a fresh left-aligned load; the gap loads zeros so the line idles low.
    always_comb begin
        state_d  = state_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_data  = '0;
        sh_len   = CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    sh_load = 1'b1;
                    sh_data = SH_W'(SYNC_WORD) << (SH_W - SYNC_LEN);
                    sh_len  = CNT_W'(SYNC_LEN);
                end
            end
            SYNC: begin
                if (sh_last) begin
                    state_d = PAYLOAD;
                    sh_load = 1'b1;
                    sh_data = SH_W'(payload_q) << (SH_W - PAYLOAD_W);
                    sh_len  = CNT_W'(PAYLOAD_W);
                end else begin
                    sh_shift = 1'b1;
                end
            end
            PAYLOAD: begin
                if (sh_last) begin
                    sh_load = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    state_d = PARITY;
                    sh_data = SH_W'(^payload_q) << (SH_W - 1);
`else
                    state_d = (GAP_BITS > 0) ? GAP : IDLE;
                    sh_len  = (GAP_BITS > 0) ? CNT_W'(GAP_BITS) : CNT_W'(1);
`endif
                end else begin
                    sh_shift = 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: begin
                sh_load = 1'b1;
                state_d = (GAP_BITS > 0) ? GAP : IDLE;
                sh_len  = (GAP_BITS > 0) ? CNT_W'(GAP_BITS) : CNT_W'(1);
            end
`endif
            GAP: begin
                if (sh_last) begin
                    state_d = IDLE;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    seq_tx_shreg #(
        .W     (SH_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (sh_data),
        .load_len  (sh_len),
        .bit_out   (sh_bit),
        .last      (sh_last)
    );

    assign in_ready   = (state_q == IDLE);
    assign ser_out    = sh_bit;
    assign ser_active = (state_q == SYNC) || (state_q == PAYLOAD) || (state_q == PARITY);
    assign sync_done  = (state_q == SYNC) && sh_last;
`ifdef SEQ_TX_PARITY_EN
    assign frame_done = (state_q == PARITY);
`else
    assign frame_done = (state_q == PAYLOAD) && sh_last;
`endif

endmodule

// File: tb/tb_seq11011_frame_tx.sv
// tb/tb_seq11011_frame_tx.sv - randomized bench for seq11011_frame_tx against a frame-queue reference model
module tb_seq11011_frame_tx;

    localparam int PW = 8;
    localparam int GB = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready, ser_out, ser_active, sync_done, frame_done;

    typedef struct packed {
        logic bit_v;
        logic act;
        logic sd;
        logic fd;
        logic rdy;
    } exp_t;

    exp_t       exp_q[$];
    logic       line_hist[$];
    logic [4:0] det_sr = '0;
    int         det_fires = 0;
    int         checks = 0;
    int         errors = 0;

    seq11011_frame_tx #(
        .PAYLOAD_W (PW),
        .GAP_BITS  (GB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .sync_done  (sync_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // A whole frame is queued at handshake: sync, payload MSB-first, optional parity, gap zeros.
    task automatic push_frame(input logic [PW-1:0] d);
        logic [4:0] sw;
        sw = 5'b11011;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(exp_t'{sw[4-i], 1'b1, (i == 4), 1'b0, 1'b0});
        for (int i = 0; i < PW; i++)
            exp_q.push_back(exp_t'{d[PW-1-i], 1'b1, 1'b0, (PAR == 0 && i == PW - 1), 1'b0});
        if (PAR == 1)
            exp_q.push_back(exp_t'{^d, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < GB; i++)
            exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Called just after a falling edge: checks this cycle, then drives inputs for the next rising edge.
    task automatic step(input logic v, input logic [PW-1:0] d);
        exp_t cur;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_val("ser_out", ser_out, cur.bit_v);
        check_val("ser_active", ser_active, cur.act);
        check_val("sync_done", sync_done, cur.sd);
        check_val("frame_done", frame_done, cur.fd);
        check_val("in_ready", in_ready, cur.rdy);
        det_sr = {det_sr[3:0], ser_out};
        if (det_sr == 5'b11011) det_fires++;
        if (cur.sd) check_val("det_align", (det_sr == 5'b11011), 1);
        line_hist.push_back(ser_out);
        in_valid = v;
        in_data  = d;
        if (v && cur.rdy) push_frame(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] hist_bits(input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = start; i < start + n; i++) r = {r[30:0], line_hist[i]};
        return r;
    endfunction

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, PW'($urandom));

        // Basic 0xA5 frame
        line_hist.delete();
        step(1'b1, 8'hA5);
        for (int i = 0; i < 18; i++) step(1'b0, PW'($urandom));
        check_val("a5_frame", hist_bits(1, 13), 32'h1BA5);
`ifdef SEQ_TX_PARITY_EN
        check_val("a5_parity", line_hist[14], 1'b0);
        line_hist.delete();
        step(1'b1, 8'h07);
        for (int i = 0; i < 18; i++) step(1'b0, PW'($urandom));
        check_val("07_parity", line_hist[14], 1'b1);
`endif

        // Back-to-back: 0xFF accepted, then 0x00 held while busy
        line_hist.delete();
        step(1'b1, 8'hFF);
        for (int i = 0; i < 40; i++) step(1'b1, 8'h00);
        check_val("b2b_gap", hist_bits(14 + PAR, 3), 0);
        check_val("b2b_sync2", hist_bits(17 + PAR, 5), 5'b11011);
        check_val("b2b_pay2", hist_bits(22 + PAR, 8), 8'h00);
        for (int i = 0; i < 25; i++) step(1'b0, PW'($urandom));

        // Reset in the middle of the payload
        step(1'b1, 8'hFF);
        for (int i = 0; i < 7; i++) step(1'b0, PW'($urandom));
        check_val("pre_rst_bit", ser_out, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_ser_out", ser_out, 1'b0);
        check_val("rst_active", ser_active, 1'b0);
        check_val("rst_sync_done", sync_done, 1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);
        check_val("rst_ready", in_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        step(1'b0, '0);
        step(1'b0, '0);
        rst_n = 1'b1;
        line_hist.delete();
        step(1'b1, 8'h3C);
        for (int i = 0; i < 20; i++) step(1'b0, PW'($urandom));
        check_val("3c_frame", hist_bits(1, 13), 32'h1B3C);

        // Loopback into an 11011 detector with an all-zero payload
        det_fires = 0;
        step(1'b1, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b0, PW'($urandom));
        check_val("det_once", det_fires, 1);

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 2) == 0), PW'($urandom));
        for (int i = 0; i < 20; i++) step(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
